lbp_window_ctrl: RTL
====================

Name: lbp_window_ctrl

Overview:
Sequencing controller for the LBP window encoding datapath (sample memory, LBP/channel bind-bundle stage, window HV buffer and window bundler). It accepts multichannel samples over a valid/ready handshake and runs the LBP priming phase, the first full window and the subsequent sliding windows. It generates the shift, push and emit strobes for the datapath, and presents each finished window HV downstream over a valid/ready handshake with backpressure.

Parameters:
WINDOW_SIZE, 256, samples in the first window
WINDOW_STEP, 128, new samples per subsequent window; legal range 1..WINDOW_SIZE
LBP_SIZE, 6, priming samples before the first LBP pattern is valid
CNT_W, $clog2(WINDOW_SIZE+1), sample counter width

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  in IDLE, begin a new encoding run; ignored in other states
stop  input  1  end the run; level-sampled
sample_valid  input  1  upstream sample vector present
sample_ready  output  1  controller accepts a sample this cycle
mem_shift_en  output  1  shift sample memory and load the new sample
win_push  output  1  push the current sample HV into the window buffer
win_emit  output  1  one-cycle pulse: latch window bundler output into the output register
hv_valid  output  1  window HV output register holds a complete window
hv_ready  input  1  downstream consumes the window HV
busy  output  1  state != IDLE
sample_cnt  output  CNT_W  samples counted in the current phase

Behaviour:
- Reset (async, nrst=0): state=IDLE, sample_cnt=0, hv_valid=0, win_emit=0, stop_pend=0. All combinational outputs are therefore 0.
- accept = sample_valid & sample_ready.
- sample_ready = (state in {PRIME, FILL, SLIDE}) & !stop & !stop_pend. This signal is combinational.
- mem_shift_en = accept in PRIME, FILL or SLIDE.
- win_push = accept in FILL or SLIDE only. It is never asserted in PRIME.
- States:
  - IDLE: on start=1 and stop=0, go to PRIME with sample_cnt=0.
  - PRIME: each accept increments sample_cnt. An accept with sample_cnt==LBP_SIZE-1 moves to FILL with sample_cnt=0. LBP_SIZE=0 is illegal.
  - FILL: each accept increments sample_cnt. An accept with sample_cnt==WINDOW_SIZE-1 sets sample_cnt=0, registers win_emit=1 and hv_valid=1 for the next cycle, and moves to HOLD.
  - SLIDE: same as FILL, but the terminal count is WINDOW_STEP-1.
  - HOLD: sample_ready=0. win_emit lasts exactly one cycle, the first HOLD cycle. When hv_valid & hv_ready, clear hv_valid next cycle and go to SLIDE, or to IDLE if stop_pend is set.
- Latency: the final accepted sample of a window is at cycle N. win_emit and hv_valid are high at N+1. The earliest next accept is N+2 when hv_ready=1 at N+1.
- hv_valid stays high and stable until the handshake. It never drops without hv_ready, including on stop.
- stop in PRIME, FILL or SLIDE: no accept that cycle; go to IDLE next cycle, sample_cnt=0; the partial window is discarded.
- stop in HOLD: set stop_pend; complete the pending handshake, then go to IDLE and clear stop_pend.
- start and stop together in IDLE: stop wins; remain in IDLE.
- start outside IDLE: no effect.
- The sample counter never exceeds WINDOW_SIZE-1 and never wraps.
- Reset asserted mid-run: immediate return to reset values; an unaccepted hv_valid is lost.

Optional Feature:
LBP_CTRL_STATS_EN. When defined, adds these outputs, each cleared by reset only:
- win_count [31:0]: increments on each hv_valid & hv_ready handshake; saturates at all-ones.
- stall_count [31:0]: increments each cycle with state==HOLD & sample_valid & !hv_ready; saturates.
When undefined, neither port nor the counter logic exists, and behaviour is otherwise identical.

Test Plan:
All scenarios use WINDOW_SIZE=8, WINDOW_STEP=4, LBP_SIZE=2.
- Priming and first window: sample_valid=1 and hv_ready=1 continuously after start -> mem_shift_en on 10 accepts, win_push only on accepts 3..10, win_emit and hv_valid one cycle after accept 10.
- Sliding: continue the stream -> each subsequent emit after exactly 4 win_push accepts, with a 1-cycle accept gap per window.
- Backpressure: hv_ready=0 for 5 cycles at the first window -> hv_valid held 5 cycles, sample_ready=0 throughout, win_emit a single pulse, no accept lost.
- Stop mid-FILL after 5 pushes -> sample_ready=0 that cycle, IDLE next cycle, no win_emit. A new start then re-primes with 2 accepts before the first win_push.
- Stop during HOLD with hv_ready=0 for 3 cycles -> hv_valid stays 1 until hv_ready, then IDLE, busy=0.
- Async reset asserted in SLIDE mid-cycle -> all outputs 0 immediately without a clock edge. With LBP_CTRL_STATS_EN defined, win_count=3 after 3 handshakes and stall_count equals the HOLD stall cycles.

Source files
------------

// File: rtl/lbp_window_ctrl.sv
// Sequencing controller for the LBP window encoder: priming, first window, sliding windows.
// Define LBP_CTRL_STATS_EN to add the saturating win_count / stall_count outputs.
module lbp_window_ctrl #(
  parameter int unsigned WINDOW_SIZE = 256,
  parameter int unsigned WINDOW_STEP = 128,
  parameter int unsigned LBP_SIZE    = 6,
  parameter int unsigned CNT_W       = $clog2(WINDOW_SIZE + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             mem_shift_en,
  output logic             win_push,
  output logic             win_emit,
  output logic             hv_valid,
  input  logic             hv_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
`ifdef LBP_CTRL_STATS_EN
  ,
  output logic [31:0]      win_count,
  output logic [31:0]      stall_count
`endif
);

  typedef enum logic [2:0] {StIdle, StPrime, StFill, StSlide, StHold} state_e;

  localparam logic [CNT_W-1:0] PrimeLast = CNT_W'(LBP_SIZE - 1);
  localparam logic [CNT_W-1:0] FillLast  = CNT_W'(WINDOW_SIZE - 1);
  localparam logic [CNT_W-1:0] SlideLast = CNT_W'(WINDOW_STEP - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hv_valid;
  logic             r_win_emit;
  logic             r_stop_pend;

  logic             w_active;
  logic             w_accept;
  logic [CNT_W-1:0] w_term;
  logic             w_last;

  assign w_active = (r_state == StPrime) || (r_state == StFill) || (r_state == StSlide);
  assign w_accept = sample_valid && sample_ready;
  assign w_term   = (r_state == StPrime) ? PrimeLast :
                    (r_state == StFill)  ? FillLast  : SlideLast;
  assign w_last   = w_accept && (r_cnt == w_term);

  assign sample_ready = w_active && !stop && !r_stop_pend;
  assign mem_shift_en = w_accept;
  assign win_push     = w_accept && (r_state != StPrime);
  assign win_emit     = r_win_emit;
  assign hv_valid     = r_hv_valid;
  assign busy         = (r_state != StIdle);
  assign sample_cnt   = r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_hv_valid  <= 1'b0;
      r_win_emit  <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_win_emit <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start && !stop) begin
            r_state <= StPrime;
            r_cnt   <= '0;
          end
        end
        StPrime, StFill, StSlide: begin
          if (stop) begin
            // Partial window is dropped; the datapath is re-primed on the next start.
            r_state <= StIdle;
            r_cnt   <= '0;
          end else if (w_accept) begin
            if (w_last) begin
              r_cnt <= '0;
              if (r_state == StPrime) begin
                r_state <= StFill;
              end else begin
                r_state    <= StHold;
                r_win_emit <= 1'b1;
                r_hv_valid <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StHold: begin
          if (stop) r_stop_pend <= 1'b1;
          if (r_hv_valid && hv_ready) begin
            r_hv_valid  <= 1'b0;
            r_stop_pend <= 1'b0;
            r_state     <= (stop || r_stop_pend) ? StIdle : StSlide;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef LBP_CTRL_STATS_EN
  logic [31:0] r_win_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_win_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_hv_valid && hv_ready && (r_win_count != '1)) begin
        r_win_count <= r_win_count + 32'd1;
      end
      if ((r_state == StHold) && sample_valid && !hv_ready && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign win_count   = r_win_count;
  assign stall_count = r_stall_count;
`endif

endmodule
